// File: rtl/norm_shifter.sv
// ---------------------------------------------------------------------------
// norm_shifter
//   Iterative normalization shifter for the FPU datapath. Takes a mantissa,
//   its leading-zero count and its biased exponent, left-shifts the mantissa
//   by the count one power-of-two stage per cycle, and lowers the exponent by
//   the same amount. When the count exceeds the exponent the shift is clamped
//   to the exponent so the result becomes subnormal instead of wrapping.
//
//   Optional feature macro: NORM_SHIFTER_BYPASS_EN
//     When defined, a request whose effective shift is zero skips the shift
//     stages and is presented on the output right after the accept edge.
//     Results are identical either way; only latency changes.
// ---------------------------------------------------------------------------
module norm_shifter #(
    parameter int WIDTH     = 24,
    parameter int CNT_WIDTH = $clog2(WIDTH),
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     data_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic [EXP_WIDTH-1:0] exp_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     data_o,
    output logic [EXP_WIDTH-1:0] exp_o,
    output logic                 underflow_o,
    output logic                 zero_o
);

    // Width wide enough to compare the count against the exponent without
    // truncating either operand.
    localparam int CMP_WIDTH = (CNT_WIDTH > EXP_WIDTH) ? CNT_WIDTH : EXP_WIDTH;

    // Index of the final power-of-two shift stage.
    localparam logic [CNT_WIDTH-1:0] LAST_STAGE = CNT_WIDTH'(CNT_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_data;
    logic [CNT_WIDTH-1:0]   r_eff;
    logic [CNT_WIDTH-1:0]   r_stage;
    logic                   r_inReady;
    logic                   r_outValid;
    logic [WIDTH-1:0]       r_dataOut;
    logic [EXP_WIDTH-1:0]   r_expOut;
    logic                   r_underflow;
    logic                   r_zero;

    logic [CMP_WIDTH-1:0]   w_cntExt;
    logic [CMP_WIDTH-1:0]   w_expExt;
    logic                   w_clamp;
    logic [CMP_WIDTH-1:0]   w_effExt;
    logic [CNT_WIDTH-1:0]   w_eff;
    logic [EXP_WIDTH-1:0]   w_expAdj;
    logic [WIDTH-1:0]       w_shifted;

    // Work out the effective shift at the input: the requested count, or the
    // exponent itself when the count would drive the exponent below zero.
    // An exponent of 2**CNT_WIDTH or more can never be smaller than the
    // count, so the clamped value always fits in CNT_WIDTH bits.
    always_comb begin
        w_cntExt = CMP_WIDTH'(cnt_i);
        w_expExt = CMP_WIDTH'(exp_i);
        w_clamp  = (w_cntExt > w_expExt);
        w_effExt = w_clamp ? w_expExt : w_cntExt;
        w_eff    = w_effExt[CNT_WIDTH-1:0];
        w_expAdj = exp_i - w_effExt[EXP_WIDTH-1:0];
    end

    // One shift stage: move the working mantissa left by 2**stage when that
    // bit of the effective count is set, zero-filling from the bottom.
    // Counts of WIDTH or more shift every bit out and leave zero.
    always_comb begin
        w_shifted = r_data;
        if (r_eff[r_stage]) begin
            w_shifted = r_data << (32'd1 << r_stage);
        end
    end

    // Control FSM with registered outputs: accept in IDLE, walk the shift
    // stages in SHIFT, then hold the result in DONE until it is taken.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_eff       <= '0;
            r_stage     <= '0;
            r_inReady   <= 1'b1;
            r_outValid  <= 1'b0;
            r_dataOut   <= '0;
            r_expOut    <= '0;
            r_underflow <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i && r_inReady) begin
                        r_data      <= data_i;
                        r_eff       <= w_eff;
                        r_stage     <= '0;
                        r_expOut    <= w_expAdj;
                        r_underflow <= w_clamp;
                        r_inReady   <= 1'b0;
`ifdef NORM_SHIFTER_BYPASS_EN
                        if (w_eff == '0) begin
                            r_dataOut  <= data_i;
                            r_zero     <= (data_i == '0);
                            r_outValid <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_state    <= ST_SHIFT;
                        end
`else
                        r_state     <= ST_SHIFT;
`endif
                    end
                end

                ST_SHIFT: begin
                    r_data  <= w_shifted;
                    r_stage <= r_stage + 1'b1;
                    if (r_stage == LAST_STAGE) begin
                        r_dataOut  <= w_shifted;
                        r_zero     <= (w_shifted == '0);
                        r_outValid <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready_i) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = r_inReady;
    assign out_valid_o = r_outValid;
    assign data_o      = r_dataOut;
    assign exp_o       = r_expOut;
    assign underflow_o = r_underflow;
    assign zero_o      = r_zero;

endmodule

// File: tb/tb_norm_shifter.sv
// ---------------------------------------------------------------------------
// tb_norm_shifter
//   Self-checking bench for norm_shifter (WIDTH=24, EXP_WIDTH=8). Directed
//   vectors, back-pressure, mid-operation reset and randomized requests are
//   compared against an arithmetic reference model. Honors the
//   NORM_SHIFTER_BYPASS_EN macro when computing expected latency.
// ---------------------------------------------------------------------------
module tb_norm_shifter;

    localparam int WIDTH     = 24;
    localparam int CNT_WIDTH = $clog2(WIDTH);
    localparam int EXP_WIDTH = 8;
    localparam int TIMEOUT   = 60;

`ifdef NORM_SHIFTER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                 clk_i;
    logic                 rst_ni;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     data_i;
    logic [CNT_WIDTH-1:0] cnt_i;
    logic [EXP_WIDTH-1:0] exp_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [WIDTH-1:0]     data_o;
    logic [EXP_WIDTH-1:0] exp_o;
    logic                 underflow_o;
    logic                 zero_o;

    int nCompared   = 0;
    int nMismatched = 0;

    norm_shifter #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .EXP_WIDTH (EXP_WIDTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .cnt_i       (cnt_i),
        .exp_i       (exp_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .exp_o       (exp_o),
        .underflow_o (underflow_o),
        .zero_o      (zero_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference model: the effective shift is the count limited to the
    // exponent; the mantissa is multiplied by 2**eff and truncated to WIDTH.
    function automatic void refModel(input int unsigned d, input int unsigned c,
                                     input int unsigned e,
                                     output int unsigned expData,
                                     output int unsigned expExp,
                                     output bit expUnder, output bit expZero,
                                     output int unsigned eff);
        longint unsigned prod;
        eff      = (c > e) ? e : c;
        prod     = longint'(d) * (64'd1 << eff);
        expData  = int'(prod % (64'd1 << WIDTH));
        expExp   = e - eff;
        expUnder = (c > e);
        expZero  = (expData == 0);
    endfunction

    // Edges after the accept edge before out_valid_o is seen. Counting the
    // accept edge itself as the first, valid appears on edge CNT_WIDTH+1
    // (or on the accept edge when the zero-shift bypass is built in).
    function automatic int expLatency(input int unsigned eff);
        if (BYPASS && eff == 0) return 0;
        return CNT_WIDTH;
    endfunction

    // Drive one request and wait (bounded) for the result. Leaves the bench
    // #1 after a rising edge with out_ready_i low.
    task automatic doRequest(input logic [WIDTH-1:0] d, input logic [CNT_WIDTH-1:0] c,
                             input logic [EXP_WIDTH-1:0] e,
                             output int lat, output bit gotValid);
        int n;
        n = 0;
        while (!in_ready_o && n < TIMEOUT) begin
            @(posedge clk_i); #1; n++;
        end
        data_i     = d;
        cnt_i      = c;
        exp_i      = e;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        data_i     = WIDTH'($urandom);
        cnt_i      = CNT_WIDTH'($urandom);
        exp_i      = EXP_WIDTH'($urandom);
        lat = 0;
        while (!out_valid_o && lat < TIMEOUT) begin
            @(posedge clk_i); #1; lat++;
        end
        gotValid = out_valid_o;
    endtask

    // Reset held for two cycles; every output must read back as idle/zero.
    task automatic test_reset();
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        data_i      = '0;
        cnt_i       = '0;
        exp_i       = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        nCompared++; if (in_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready_o); end
        nCompared++; if (out_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid_o); end
        nCompared++; if (data_o !== '0) begin nMismatched++; $display("[TB] FAIL reset_data got=%h want=0", data_o); end
        nCompared++; if (exp_o !== '0) begin nMismatched++; $display("[TB] FAIL reset_exp got=%0d want=0", exp_o); end
        nCompared++; if (underflow_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_underflow got=%b want=0", underflow_o); end
        nCompared++; if (zero_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_zero got=%b want=0", zero_o); end
    endtask

    // Fixed vectors with hand-computed results: plain normalize, clamp to
    // subnormal, and an all-zero mantissa with an oversize count.
    task automatic test_directed();
        logic [WIDTH-1:0]     vData [3];
        logic [CNT_WIDTH-1:0] vCnt  [3];
        logic [EXP_WIDTH-1:0] vExp  [3];
        logic [WIDTH-1:0]     wData [3];
        logic [EXP_WIDTH-1:0] wExp  [3];
        logic                 wUnd  [3];
        logic                 wZero [3];
        int                   wLat  [3];
        int lat;
        bit got;
        vData[0] = 24'h000F00; vCnt[0] = 5'd12; vExp[0] = 8'd100;
        wData[0] = 24'hF00000; wExp[0] = 8'd88;  wUnd[0] = 1'b0; wZero[0] = 1'b0; wLat[0] = CNT_WIDTH;
        vData[1] = 24'h000001; vCnt[1] = 5'd23; vExp[1] = 8'd5;
        wData[1] = 24'h000020; wExp[1] = 8'd0;   wUnd[1] = 1'b1; wZero[1] = 1'b0; wLat[1] = CNT_WIDTH;
        vData[2] = 24'h000000; vCnt[2] = 5'd31; vExp[2] = 8'd200;
        wData[2] = 24'h000000; wExp[2] = 8'd169; wUnd[2] = 1'b0; wZero[2] = 1'b1; wLat[2] = CNT_WIDTH;
        for (int i = 0; i < 3; i++) begin
            doRequest(vData[i], vCnt[i], vExp[i], lat, got);
            nCompared++; if (!got) begin nMismatched++; $display("[TB] FAIL dir%0d_timeout no out_valid within %0d cycles", i, TIMEOUT); end
            nCompared++; if (lat !== wLat[i]) begin nMismatched++; $display("[TB] FAIL dir%0d_latency got=%0d want=%0d", i, lat, wLat[i]); end
            nCompared++; if (data_o !== wData[i]) begin nMismatched++; $display("[TB] FAIL dir%0d_data got=%h want=%h", i, data_o, wData[i]); end
            nCompared++; if (exp_o !== wExp[i]) begin nMismatched++; $display("[TB] FAIL dir%0d_exp got=%0d want=%0d", i, exp_o, wExp[i]); end
            nCompared++; if (underflow_o !== wUnd[i]) begin nMismatched++; $display("[TB] FAIL dir%0d_underflow got=%b want=%b", i, underflow_o, wUnd[i]); end
            nCompared++; if (zero_o !== wZero[i]) begin nMismatched++; $display("[TB] FAIL dir%0d_zero got=%b want=%b", i, zero_o, wZero[i]); end
            out_ready_i = 1'b1;
            @(posedge clk_i); #1;
            out_ready_i = 1'b0;
            nCompared++; if (out_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL dir%0d_valid_drop got=%b want=0", i, out_valid_o); end
        end
    endtask

    // Consumer stalls for 10 cycles while a new request is offered: result
    // must hold, no second accept, then return to IDLE one edge after release.
    task automatic test_backpressure();
        int lat;
        bit got;
        doRequest(24'h000F00, 5'd12, 8'd100, lat, got);
        nCompared++; if (!got) begin nMismatched++; $display("[TB] FAIL bp_timeout no out_valid within %0d cycles", TIMEOUT); end
        in_valid_i = 1'b1;
        data_i     = 24'h123456;
        cnt_i      = 5'd3;
        exp_i      = 8'd50;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            nCompared++; if (out_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_valid cyc%0d got=%b want=1", i, out_valid_o); end
            nCompared++; if (in_ready_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_in_ready cyc%0d got=%b want=0", i, in_ready_o); end
            nCompared++; if (data_o !== 24'hF00000) begin nMismatched++; $display("[TB] FAIL bp_data cyc%0d got=%h want=f00000", i, data_o); end
            nCompared++; if (exp_o !== 8'd88) begin nMismatched++; $display("[TB] FAIL bp_exp cyc%0d got=%0d want=88", i, exp_o); end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        nCompared++; if (in_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_release_ready got=%b want=1", in_ready_o); end
        nCompared++; if (out_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_release_valid got=%b want=0", out_valid_o); end
    endtask

    // Reset during the second shift cycle drops the request silently.
    task automatic test_reset_mid();
        int seen;
        data_i     = 24'h0000FF;
        cnt_i      = 5'd3;
        exp_i      = 8'd40;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_o) seen++;
            @(posedge clk_i); #1;
        end
        nCompared++; if (seen !== 0) begin nMismatched++; $display("[TB] FAIL midreset_valid got=%0d valid cycles want=0", seen); end
        nCompared++; if (in_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL midreset_ready got=%b want=1", in_ready_o); end
        nCompared++; if (data_o !== '0) begin nMismatched++; $display("[TB] FAIL midreset_data got=%h want=0", data_o); end
    endtask

    // Zero shift count: same result as the data, latency depends on bypass.
    task automatic test_zero_count();
        int lat;
        bit got;
        doRequest(24'hABCDEF, 5'd0, 8'd77, lat, got);
        nCompared++; if (!got) begin nMismatched++; $display("[TB] FAIL zc_timeout no out_valid within %0d cycles", TIMEOUT); end
        nCompared++; if (lat !== expLatency(0)) begin nMismatched++; $display("[TB] FAIL zc_latency got=%0d want=%0d", lat, expLatency(0)); end
        nCompared++; if (data_o !== 24'hABCDEF) begin nMismatched++; $display("[TB] FAIL zc_data got=%h want=abcdef", data_o); end
        nCompared++; if (exp_o !== 8'd77) begin nMismatched++; $display("[TB] FAIL zc_exp got=%0d want=77", exp_o); end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
    endtask

    // Randomized requests with random consumer stalls, checked against the model.
    task automatic test_random();
        int unsigned d, c, e, wData, wExp, eff;
        bit wUnd, wZero, got;
        int lat, stall;
        for (int n = 0; n < 60; n++) begin
            d = $urandom_range(0, 3) == 0 ? ($urandom & 32'hFF) : ($urandom & 32'hFFFFFF);
            c = $urandom_range(0, 31);
            e = $urandom_range(0, 1) == 0 ? $urandom_range(0, 40) : $urandom_range(0, 255);
            refModel(d, c, e, wData, wExp, wUnd, wZero, eff);
            doRequest(WIDTH'(d), CNT_WIDTH'(c), EXP_WIDTH'(e), lat, got);
            nCompared++; if (!got) begin nMismatched++; $display("[TB] FAIL rnd%0d_timeout no out_valid within %0d cycles", n, TIMEOUT); end
            nCompared++; if (lat !== expLatency(eff)) begin nMismatched++; $display("[TB] FAIL rnd%0d_latency got=%0d want=%0d", n, lat, expLatency(eff)); end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk_i); #1;
            end
            nCompared++; if (data_o !== WIDTH'(wData)) begin nMismatched++; $display("[TB] FAIL rnd%0d_data d=%h c=%0d e=%0d got=%h want=%h", n, d, c, e, data_o, wData); end
            nCompared++; if (exp_o !== EXP_WIDTH'(wExp)) begin nMismatched++; $display("[TB] FAIL rnd%0d_exp c=%0d e=%0d got=%0d want=%0d", n, c, e, exp_o, wExp); end
            nCompared++; if (underflow_o !== wUnd) begin nMismatched++; $display("[TB] FAIL rnd%0d_underflow got=%b want=%b", n, underflow_o, wUnd); end
            nCompared++; if (zero_o !== wZero) begin nMismatched++; $display("[TB] FAIL rnd%0d_zero got=%b want=%b", n, zero_o, wZero); end
            out_ready_i = 1'b1;
            @(posedge clk_i); #1;
            out_ready_i = 1'b0;
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_zero_count();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "[TB] global timeout");
    end

endmodule
